// File: rtl/bpu_update_ctrl.sv
// Branch predictor update controller: post-reset PHT/BTB sweep, resolution FIFO and a
// forwarding 2-bit counter update pipeline. Define BPU_FLUSH_EN to add the flush input.
module bpu_update_ctrl #(
  parameter  int PC_IDX_W   = 6,
  parameter  int HIST_W     = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDX_W      = PC_IDX_W + HIST_W
) (
  input  logic                clk,
  input  logic                rst,
`ifdef BPU_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [31:0]         res_pc,
  input  logic                res_taken,
  input  logic                inv_valid,
  input  logic [31:0]         inv_pc,
  output logic [IDX_W-1:0]    pht_ra,
  input  logic [1:0]          pht_rd,
  output logic                pht_we,
  output logic [IDX_W-1:0]    pht_wa,
  output logic [1:0]          pht_wd,
  output logic                btb_clr_we,
  output logic [PC_IDX_W-1:0] btb_clr_idx,
  output logic [HIST_W-1:0]   ghr,
  output logic                init_busy
);

  localparam int               AW     = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] K_LAST = '1;

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [PC_IDX_W-1:0] pc_idx;
    logic                taken;
  } res_t;

  state_t           state;
  logic [IDX_W-1:0] k;
  logic             flush_i;

`ifdef BPU_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Resolution FIFO
  res_t        fifo_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  res_t        head;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign res_ready = ~full;
  assign push      = res_valid & ~full;
  assign pop       = (state == RUN) & ~empty & ~flush_i;
  assign head      = fifo_q[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr[AW-1:0]] <= {res_pc[2 +: PC_IDX_W], res_taken};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i && state == RUN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Update pipeline: read at pop, compute next cycle, write the cycle after
  logic [HIST_W:0]  ghr_sh;
  logic             s1_vld, s1_taken;
  logic [IDX_W-1:0] s1_idx;
  logic             prev_we;
  logic [IDX_W-1:0] prev_wa;
  logic [1:0]       prev_wd;
  logic [1:0]       base, upd;

  assign pht_ra = {head.pc_idx, ghr};
  assign ghr_sh = {ghr, head.taken};

  // The read misses the write on the port now and the one from last cycle, so patch those in.
  always_comb begin
    base = pht_rd;
    if (pht_we && pht_wa == s1_idx)        base = pht_wd;
    else if (prev_we && prev_wa == s1_idx) base = prev_wd;
    upd = base;
    if (s1_taken) begin
      if (base != 2'b11) upd = base + 2'b01;
    end else begin
      if (base != 2'b00) upd = base - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT;
      k           <= '0;
      ghr         <= '0;
      s1_vld      <= 1'b0;
      s1_idx      <= '0;
      s1_taken    <= 1'b0;
      pht_we      <= 1'b0;
      pht_wa      <= '0;
      pht_wd      <= 2'b00;
      prev_we     <= 1'b0;
      prev_wa     <= '0;
      prev_wd     <= 2'b00;
      btb_clr_we  <= 1'b0;
      btb_clr_idx <= '0;
      init_busy   <= 1'b1;
    end else begin
      prev_we   <= pht_we;
      prev_wa   <= pht_wa;
      prev_wd   <= pht_wd;
      init_busy <= (state == INIT);
      s1_vld    <= pop;
      if (pop) begin
        s1_idx   <= pht_ra;
        s1_taken <= head.taken;
        ghr      <= ghr_sh[HIST_W-1:0];
      end
      if (flush_i) begin
        state      <= INIT;
        k          <= '0;
        init_busy  <= 1'b1;
        pht_we     <= 1'b0;
        btb_clr_we <= 1'b0;
        s1_vld     <= 1'b0;
        if (state == RUN) ghr <= '0;
      end else begin
        case (state)
          INIT: begin
            pht_we      <= 1'b1;
            pht_wa      <= k;
            pht_wd      <= 2'b01;
            btb_clr_we  <= ((k >> PC_IDX_W) == '0);
            btb_clr_idx <= k[PC_IDX_W-1:0];
            k           <= k + 1'b1;
            if (k == K_LAST) state <= RUN;
          end
          RUN: begin
            pht_we      <= s1_vld;
            pht_wa      <= s1_idx;
            pht_wd      <= upd;
            btb_clr_we  <= inv_valid;
            btb_clr_idx <= inv_pc[2 +: PC_IDX_W];
          end
          default: state <= INIT;
        endcase
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{res_pc[31:2+PC_IDX_W], res_pc[1:0],
                         inv_pc[31:2+PC_IDX_W], inv_pc[1:0], ghr_sh[HIST_W]};

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Randomized bench for bpu_update_ctrl: PHT memory model, sequential counter reference
// and scoreboard of update writes, plus directed sweep/forwarding/invalidate checks.
module tb_bpu_update_ctrl;
  localparam int PCW  = 2;
  localparam int HW   = 1;
  localparam int IW   = PCW + HW;
  localparam int NENT = 1 << IW;

  logic           clk = 1'b0;
  logic           rst;
`ifdef BPU_FLUSH_EN
  logic           flush;
`endif
  logic           res_valid, res_ready, res_taken;
  logic [31:0]    res_pc;
  logic           inv_valid;
  logic [31:0]    inv_pc;
  logic [IW-1:0]  pht_ra, pht_wa;
  logic [1:0]     pht_rd, pht_wd;
  logic           pht_we;
  logic           btb_clr_we;
  logic [PCW-1:0] btb_clr_idx;
  logic [HW-1:0]  ghr;
  logic           init_busy;

  bpu_update_ctrl #(.PC_IDX_W(PCW), .HIST_W(HW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
`ifdef BPU_FLUSH_EN
    .flush(flush),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc), .res_taken(res_taken),
    .inv_valid(inv_valid), .inv_pc(inv_pc),
    .pht_ra(pht_ra), .pht_rd(pht_rd), .pht_we(pht_we), .pht_wa(pht_wa), .pht_wd(pht_wd),
    .btb_clr_we(btb_clr_we), .btb_clr_idx(btb_clr_idx), .ghr(ghr), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // PHT storage: synchronous read, old data on read-during-write
  logic [1:0] pht_mem [NENT];
  always @(posedge clk) begin
    pht_rd <= pht_mem[pht_ra];
    if (pht_we) pht_mem[pht_wa] <= pht_wd;
  end

  typedef struct { int idx; int val; } upd_t;
  upd_t expq[$];
  int   mpht [NENT];
  int   mghr;
  int   sweep_k;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    mghr = 0;
    sweep_k = 0;
    foreach (mpht[i]) mpht[i] = 1;
  endtask

  // Resolutions take effect in push order, so the table can be updated sequentially here.
  task automatic push_drive(input logic [31:0] pc, input logic tk);
    int idx, cur, nv;
    res_valid = 1'b1; res_pc = pc; res_taken = tk;
    idx = int'((pc >> 2) & ((1 << PCW) - 1)) * (1 << HW) + mghr;
    cur = mpht[idx];
    nv  = tk ? ((cur == 3) ? 3 : cur + 1) : ((cur == 0) ? 0 : cur - 1);
    mpht[idx] = nv;
    expq.push_back('{idx, nv});
    mghr = (mghr * 2 + int'(tk)) % (1 << HW);
  endtask

  // Scoreboard of every PHT write
  always @(negedge clk) begin
    if (!rst && pht_we) begin
      if (init_busy) begin
        chk("sweep_wa", 32'(pht_wa), sweep_k);
        chk("sweep_wd", 32'(pht_wd), 1);
        sweep_k++;
      end else if (expq.size() == 0) begin
        chk("upd_extra", 32'(pht_wa), 32'hFFFF_FFFF);
      end else begin
        upd_t e;
        e = expq.pop_front();
        chk("upd_wa", 32'(pht_wa), e.idx);
        chk("upd_wd", 32'(pht_wd), e.val);
      end
    end
  end

  int dir_wa [4] = '{4, 5, 5, 5};
  int dir_wd [4] = '{2, 2, 3, 3};

  initial begin
    bit found;
    bit inv_pend;
    int inv_idx;
    rst = 1'b1; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
    inv_valid = 1'b0; inv_pc = '0;
`ifdef BPU_FLUSH_EN
    flush = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(res_ready), 1);
    chk("rst_busy", 32'(init_busy), 1);
    chk("rst_pht_we", 32'(pht_we), 0);
    chk("rst_btb_we", 32'(btb_clr_we), 0);
    chk("rst_ghr", 32'(ghr), 0);
    rst = 1'b0;

    // Sweep; four resolutions queued while popping is held off, one invalidate dropped
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("sweep_we", 32'(pht_we), 1);
      chk("sweep_wa_d", 32'(pht_wa), c - 1);
      chk("sweep_busy", 32'(init_busy), 1);
      chk("sweep_btb_we", 32'(btb_clr_we), (c <= 4) ? 1 : 0);
      if (c <= 4) chk("sweep_btb_idx", 32'(btb_clr_idx), c - 1);
      if (c >= 5 && c <= 7) chk("ready_full", 32'(res_ready), 0);
      res_valid = 1'b0; inv_valid = 1'b0;
      if (c <= 4) begin
        chk("ready_pre", 32'(res_ready), 1);
        push_drive(32'h8, 1'b1);
      end
      if (c == 5) begin inv_valid = 1'b1; inv_pc = 32'hC; end
    end
    @(negedge clk);
    chk("busy_drop", 32'(init_busy), 0);

    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      if (pht_we && !init_busy) found = 1'b1;
      else @(negedge clk);
    end
    chk("drain_start", 32'(found), 1);
    chk("ready_rise", 32'(res_ready), 1);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      chk("fwd_we", 32'(pht_we), 1);
      chk("fwd_wa", 32'(pht_wa), dir_wa[j]);
      chk("fwd_wd", 32'(pht_wd), dir_wd[j]);
    end
    @(negedge clk);
    chk("ghr_after_fwd", 32'(ghr), 1);
    inv_valid = 1'b1; inv_pc = 32'hC;
    @(negedge clk);
    inv_valid = 1'b0;
    chk("inv_we", 32'(btb_clr_we), 1);
    chk("inv_idx", 32'(btb_clr_idx), 3);
    push_drive(32'h8, 1'b0);
    @(negedge clk);
    res_valid = 1'b0;
    chk("inv_once", 32'(btb_clr_we), 0);
    repeat (2) @(negedge clk);

    // Single taken resolution from ghr=0
    @(negedge clk);
    push_drive(32'h4, 1'b1);
    @(negedge clk);
    res_valid = 1'b0;
    chk("pop_ra", 32'(pht_ra), 2);
    chk("pop_ghr", 32'(ghr), 0);
    @(negedge clk);
    chk("ghr_upd", 32'(ghr), 1);
    chk("no_early_we", 32'(pht_we), 0);
    @(negedge clk);
    chk("single_we", 32'(pht_we), 1);
    chk("single_wa", 32'(pht_wa), 2);
    chk("single_wd", 32'(pht_wd), 2);

`ifdef BPU_FLUSH_EN
    @(negedge clk);
    push_drive(32'h8, 1'b1);
    @(negedge clk);
    push_drive(32'hC, 1'b0);
    @(negedge clk);
    res_valid = 1'b0;
    flush = 1'b1;
    model_reset();
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(init_busy), 1);
    chk("flush_ghr", 32'(ghr), 0);
    chk("flush_we", 32'(pht_we), 0);
    chk("flush_ready", 32'(res_ready), 1);
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (!init_busy) found = 1'b1;
    end
    chk("flush_sweep_done", 32'(found), 1);
`endif

    // Randomized traffic with occasional resets mid-sweep and mid-update
    @(negedge clk);
    rst = 1'b1; model_reset();
    @(negedge clk);
    rst = 1'b0;
    inv_pend = 1'b0;
    inv_idx = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (inv_pend) begin
        chk("rnd_inv_we", 32'(btb_clr_we), 1);
        chk("rnd_inv_idx", 32'(btb_clr_idx), inv_idx);
      end else if (!init_busy) begin
        chk("rnd_btb_idle", 32'(btb_clr_we), 0);
      end
      inv_pend = 1'b0; res_valid = 1'b0; inv_valid = 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1; model_reset();
        @(negedge clk);
        rst = 1'b0;
        continue;
      end
      if (!init_busy && $urandom_range(0, 3) == 0) begin
        inv_valid = 1'b1; inv_pc = $urandom;
        inv_pend = 1'b1; inv_idx = int'((inv_pc >> 2) & ((1 << PCW) - 1));
      end
      if (res_ready && $urandom_range(0, 2) != 0) push_drive($urandom, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    res_valid = 1'b0; inv_valid = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 60 && !found; w++) begin
      @(negedge clk);
      if (!init_busy && expq.size() == 0 && !pht_we) found = 1'b1;
    end
    chk("drain_done", 32'(found), 1);
    chk("drain_empty", expq.size(), 0);
    chk("final_ghr", 32'(ghr), mghr);
    chk("final_ready", 32'(res_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bpu_update_ctrl.md
BPU_UPDATE_CTRL -- requirements
Module: bpu_update_ctrl

Interface
REQ-001 Parameter PC_IDX_W, default 6: PC index bits, taken from pc[2 +: PC_IDX_W].
REQ-002 Parameter HIST_W, default 2: global history width.
REQ-003 Parameter FIFO_DEPTH, default 4: resolution queue depth, power of two.
REQ-004 IDX_W = PC_IDX_W + HIST_W is the PHT index width.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 res_valid  in  1  EX branch resolution offered.
REQ-008 res_ready  out  1  resolution queue can accept an entry.
REQ-009 res_pc  in  32  resolved branch PC.
REQ-010 res_taken  in  1  resolved branch direction.
REQ-011 inv_valid  in  1  IF2 BTB invalidate, single-cycle pulse.
REQ-012 inv_pc  in  32  PC whose BTB entry is cleared.
REQ-013 pht_ra  out  IDX_W  PHT read address, combinational.
REQ-014 pht_rd  in  2  PHT read data, one cycle after pht_ra; read-during-write returns old data.
REQ-015 pht_we / pht_wa / pht_wd  out  1 / IDX_W / 2  PHT write port, registered.
REQ-016 btb_clr_we / btb_clr_idx  out  1 / PC_IDX_W  BTB entry-clear port, registered.
REQ-017 ghr  out  HIST_W  global history for fetch lookup.
REQ-018 init_busy  out  1  table sweep in progress; BPU suppresses predictions and BTB fills while it is high.

Function
REQ-019 FSM states are INIT and RUN; reset enters INIT with sweep counter k=0.
REQ-020 INIT: the (k+1)-th cycle after reset release drives pht_we=1, pht_wa=k, pht_wd=2'b01, for k=0..2^IDX_W-1.
REQ-021 INIT: btb_clr_we=1 and btb_clr_idx=k for k<2^PC_IDX_W.
REQ-022 INIT exits to RUN after k=2^IDX_W-1; init_busy is 0 from the cycle following the last sweep write.
REQ-023 inv_valid during INIT is dropped.
REQ-024 inv_valid in RUN produces btb_clr_we=1, btb_clr_idx=inv_pc[2 +: PC_IDX_W] in the next cycle.
REQ-025 The queue is FIFO with res_ready = ~full; an entry is pushed on res_valid & res_ready in either state.
REQ-026 A simultaneous push and pop when full is not allowed: ready stays 0 when full.
REQ-027 Pop happens in RUN whenever the queue is non-empty, at most one pop per cycle.
REQ-028 Pop cycle t: pht_ra = {pc[2 +: PC_IDX_W], ghr}; in the same edge ghr <= {ghr[HIST_W-2:0], taken}.
REQ-029 Cycle t+1: base = pht_rd; new = saturating +1 if taken, -1 if not taken, clamped to 0..3.
REQ-030 The write appears at t+2 as pht_we=1, pht_wa=idx, pht_wd=new.
REQ-031 Forwarding: if idx equals the write currently on the port, use its pht_wd as base; else if idx equals the write issued the previous cycle, use that value; else use pht_rd. The youngest match wins.
REQ-032 Back-to-back pops to the same index therefore count cumulatively.

Reset
REQ-033 Asynchronous rst: FIFO empty, ghr=0, pipeline invalid, pht_we=0, btb_clr_we=0, init_busy=1, res_ready=1, state INIT, k=0.
REQ-034 rst mid-sweep or mid-update discards all queued and in-flight updates and restarts the sweep at k=0.

Configuration
REQ-035 With BPU_FLUSH_EN defined, an input port flush (1 bit) exists.
REQ-036 BPU_FLUSH_EN, flush in RUN: empty the FIFO, kill in-flight updates (no write issued), set ghr=0, enter INIT with k=0.
REQ-037 BPU_FLUSH_EN, flush in INIT: restart k=0.
REQ-038 Without BPU_FLUSH_EN: no flush port; only rst restarts the sweep.

Verification
REQ-039 Reset release with PC_IDX_W=2, HIST_W=1 -> 8 writes, wa=0..7, wd=01; btb_clr idx 0..3; init_busy low in cycle 9.
REQ-040 RUN, ghr=0, resolution pc=0x8 taken -> pht_ra=0b0100 at pop; pht_we wa=0b0100 wd=10 two cycles later; ghr=1.
REQ-041 Three consecutive taken resolutions, HIST_W=1, pc=0x8, starting ghr=1, all read index 0b0101 -> written values 10, 11, 11 (forwarding and saturation).
REQ-042 Hold pop off (INIT), push 4 entries -> res_ready=0; after INIT, pops drain one per cycle and res_ready rises after the first pop.
REQ-043 inv_valid with inv_pc=0xC in RUN -> btb_clr_we=1, idx=3 next cycle; the same pulse during INIT -> no extra clear.
REQ-044 BPU_FLUSH_EN: flush one cycle after a pop -> no pht_we for that entry; FIFO empty; ghr=0; init_busy=1.
